// File: rtl/mips_mem_pkg.sv
// Shared encodings and lane-steering / extension helpers for the MIPS MEM stage.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int WB_REGWRITE = 0;
  localparam int WB_MEMTOREG = 1;

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: is_illegal = 1'b0;
      SZ_HALF: is_illegal = lo[0];
      SZ_WORD: is_illegal = (lo != 2'b00);
      default: is_illegal = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] lane_enable(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_enable = 4'b0001 << lo;
      SZ_HALF: lane_enable = lo[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_enable = 4'b1111;
      default: lane_enable = 4'b0000;
    endcase
  endfunction

  // Replicate the low bytes so every enabled lane sees the right store byte.
  function automatic logic [31:0] store_steer(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: store_steer = {4{data[7:0]}};
      SZ_HALF: store_steer = {2{data[15:0]}};
      default: store_steer = data;
    endcase
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: load_extract = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      SZ_HALF: load_extract = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      default: load_extract = word;
    endcase
  endfunction

endpackage

// File: rtl/data_ram_bytelane.sv
// Word-organised data RAM: synchronous byte-enabled write, combinational read.
module data_ram_bytelane #(
  parameter int DEPTH_W = 10
) (
  input  logic               clk,
  input  logic [DEPTH_W-1:0] addr,
  input  logic [3:0]         be,
  input  logic [31:0]        wdata,
  output logic [31:0]        rdata
);

  logic [31:0] mem [0:(1 << DEPTH_W)-1];

  // Byte-lane write port
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (be[i]) begin
        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: load/store against an internal RAM with optional wait states,
// producing a registered, aligned and extended MEM/WB bundle.
module mem_access_stage
  import mips_mem_pkg::*;
#(
  parameter int DEPTH_W     = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [1:0]  mem_size,
  input  logic        mem_unsigned,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [1:0]  wb_ctrl_in,
  input  logic [4:0]  dest_reg_in,
  output logic        stall,
  output logic        out_valid,
  output logic        fault,
  output logic [31:0] read_data,
  output logic [31:0] alu_out,
  output logic [1:0]  wb_ctrl_out,
  output logic [4:0]  dest_reg_out
);

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  state_t      state_r, state_nxt_s;
  logic [3:0]  cnt_r, cnt_nxt_s;
  logic [31:0] req_addr_r, req_data_r;
  logic [1:0]  req_size_r, req_wb_r;
  logic        req_uns_r, req_write_r;
  logic [4:0]  req_dest_r;

  logic        in_mem_s, in_illegal_s, complete_s;
  logic [31:0] act_addr_s, act_data_s;
  logic [1:0]  act_size_s, act_wb_s;
  logic        act_uns_s, act_write_s;
  logic [4:0]  act_dest_s;
  logic [3:0]  ram_be_s;
  logic [31:0] ram_wdata_s, ram_rdata_s, load_val_s;

  assign in_mem_s     = mem_read | mem_write;
  assign in_illegal_s = in_mem_s & ((mem_read & mem_write) | is_illegal(mem_size, alu_result[1:0]));
  assign stall        = (state_r == WAIT);

  // Request being serviced: the captured one while waiting, the live inputs otherwise
  always_comb begin
    if (state_r == WAIT) begin
      act_addr_s = req_addr_r;  act_data_s  = req_data_r;  act_size_s = req_size_r;
      act_uns_s  = req_uns_r;   act_write_s = req_write_r; act_wb_s   = req_wb_r;
      act_dest_s = req_dest_r;
    end else begin
      act_addr_s = alu_result;   act_data_s  = store_data; act_size_s = mem_size;
      act_uns_s  = mem_unsigned; act_write_s = mem_write;  act_wb_s   = wb_ctrl_in;
      act_dest_s = dest_reg_in;
    end
  end

  // Completion strobe; never fires while reset is held so no stray RAM write occurs
  always_comb begin
    complete_s = 1'b0;
    if (reset) begin
      complete_s = 1'b0;
    end else if (state_r == WAIT) begin
      complete_s = (cnt_r <= 4'd1);
    end else if (WS == 4'd0) begin
      complete_s = in_valid & in_mem_s & ~in_illegal_s;
    end else begin
      complete_s = 1'b0;
    end
  end

  assign ram_be_s    = (complete_s & act_write_s) ? lane_enable(act_size_s, act_addr_s[1:0]) : 4'b0000;
  assign ram_wdata_s = store_steer(act_size_s, act_data_s);
  assign load_val_s  = load_extract(ram_rdata_s, act_size_s, act_addr_s[1:0], act_uns_s);

  data_ram_bytelane #(.DEPTH_W(DEPTH_W)) u_ram (
    .clk   (clk),
    .addr  (act_addr_s[DEPTH_W+1:2]),
    .be    (ram_be_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  // Next-state and wait-counter decode
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (in_valid && in_mem_s && !in_illegal_s && (WS != 4'd0)) begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = WS;
        end else begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end
      end
      WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = WAIT;
          cnt_nxt_s   = cnt_r - 4'd1;
        end
      end
      default: begin
        state_nxt_s = IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
    end
  end

  // Capture the request whenever the stage accepts an instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_addr_r <= 32'h0; req_data_r  <= 32'h0; req_size_r <= 2'b00; req_uns_r <= 1'b0;
      req_write_r <= 1'b0; req_wb_r    <= 2'b00; req_dest_r <= 5'd0;
    end else if (state_r == IDLE && in_valid) begin
      req_addr_r <= alu_result; req_data_r <= store_data; req_size_r <= mem_size;
      req_uns_r  <= mem_unsigned; req_write_r <= mem_write; req_wb_r <= wb_ctrl_in;
      req_dest_r <= dest_reg_in;
    end
  end

  // MEM/WB output bundle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0; fault <= 1'b0; read_data <= 32'h0; alu_out <= 32'h0;
      wb_ctrl_out <= 2'b00; dest_reg_out <= 5'd0;
    end else if (complete_s) begin
      out_valid    <= 1'b1;
      fault        <= 1'b0;
      read_data    <= act_write_s ? 32'h0 : load_val_s;
      alu_out      <= act_addr_s;
      wb_ctrl_out  <= act_wb_s;
      dest_reg_out <= act_dest_s;
    end else if (state_r == WAIT || !in_valid || (in_mem_s && !in_illegal_s)) begin
      out_valid   <= 1'b0;
      wb_ctrl_out <= 2'b00;
    end else begin
      out_valid    <= 1'b1;
      fault        <= in_illegal_s;
      read_data    <= 32'h0;
      alu_out      <= alu_result;
      dest_reg_out <= dest_reg_in;
      wb_ctrl_out[WB_REGWRITE] <= ~in_illegal_s & wb_ctrl_in[WB_REGWRITE];
      wb_ctrl_out[WB_MEMTOREG] <= ~in_illegal_s & wb_ctrl_in[WB_MEMTOREG];
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: vector table on a zero-wait instance,
// hand sequences on 2- and 3-wait-state instances for stall and reset corners.
module tb_mem_access_stage;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, mem_read, mem_write, mem_unsigned;
  logic [1:0]  mem_size, wb_ctrl_in;
  logic [31:0] alu_result, store_data;
  logic [4:0]  dest_reg_in;

  logic        u0_stall, u0_out_valid, u0_fault;
  logic [31:0] u0_read_data, u0_alu_out;
  logic [1:0]  u0_wb_ctrl_out;
  logic [4:0]  u0_dest_reg_out;
  logic        u2_stall, u2_out_valid, u2_fault;
  logic [31:0] u2_read_data, u2_alu_out;
  logic [1:0]  u2_wb_ctrl_out;
  logic [4:0]  u2_dest_reg_out;
  logic        u3_stall, u3_out_valid, u3_fault;
  logic [31:0] u3_read_data, u3_alu_out;
  logic [1:0]  u3_wb_ctrl_out;
  logic [4:0]  u3_dest_reg_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.DEPTH_W(10), .WAIT_STATES(0)) u0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result(alu_result),
    .store_data(store_data), .wb_ctrl_in(wb_ctrl_in), .dest_reg_in(dest_reg_in),
    .stall(u0_stall), .out_valid(u0_out_valid), .fault(u0_fault), .read_data(u0_read_data),
    .alu_out(u0_alu_out), .wb_ctrl_out(u0_wb_ctrl_out), .dest_reg_out(u0_dest_reg_out));

  mem_access_stage #(.DEPTH_W(10), .WAIT_STATES(2)) u2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result(alu_result),
    .store_data(store_data), .wb_ctrl_in(wb_ctrl_in), .dest_reg_in(dest_reg_in),
    .stall(u2_stall), .out_valid(u2_out_valid), .fault(u2_fault), .read_data(u2_read_data),
    .alu_out(u2_alu_out), .wb_ctrl_out(u2_wb_ctrl_out), .dest_reg_out(u2_dest_reg_out));

  mem_access_stage #(.DEPTH_W(10), .WAIT_STATES(3)) u3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
    .mem_size(mem_size), .mem_unsigned(mem_unsigned), .alu_result(alu_result),
    .store_data(store_data), .wb_ctrl_in(wb_ctrl_in), .dest_reg_in(dest_reg_in),
    .stall(u3_stall), .out_valid(u3_out_valid), .fault(u3_fault), .read_data(u3_read_data),
    .alu_out(u3_alu_out), .wb_ctrl_out(u3_wb_ctrl_out), .dest_reg_out(u3_dest_reg_out));

  typedef struct {
    logic v, rd, wr; logic [1:0] sz; logic uns; logic [31:0] addr, sd; logic [1:0] wb; logic [4:0] dest;
    logic ev, ef; logic [31:0] erd; logic [1:0] ewb; logic [31:0] ealu; logic [4:0] edest;
  } vec_t;

  vec_t vecs [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic rd, input logic wr, input logic [1:0] sz,
                       input logic uns, input logic [31:0] a, input logic [31:0] sd,
                       input logic [1:0] wb, input logic [4:0] d);
    in_valid = v; mem_read = rd; mem_write = wr; mem_size = sz; mem_unsigned = uns;
    alu_result = a; store_data = sd; wb_ctrl_in = wb; dest_reg_in = d;
  endtask

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, 2'b00, 5'd0);

    //                v     rd    wr    sz       uns   addr           sdata          wb     dest     ev    ef    erd            ewb    ealu           edest
    vecs[0]  = '{1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h00000010, 32'hDEADBEEF, 2'b00, 5'd0,  1'b1, 1'b0, 32'h00000000, 2'b00, 32'h00000010, 5'd0};
    vecs[1]  = '{1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00000010, 32'h00000000, 2'b11, 5'd8,  1'b1, 1'b0, 32'hDEADBEEF, 2'b11, 32'h00000010, 5'd8};
    vecs[2]  = '{1'b1, 1'b0, 1'b1, SZ_BYTE, 1'b0, 32'h00000013, 32'h00000080, 2'b00, 5'd0,  1'b1, 1'b0, 32'h00000000, 2'b00, 32'h00000013, 5'd0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h00000013, 32'h00000000, 2'b11, 5'd9,  1'b1, 1'b0, 32'hFFFFFF80, 2'b11, 32'h00000013, 5'd9};
    vecs[4]  = '{1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h00000013, 32'h00000000, 2'b11, 5'd10, 1'b1, 1'b0, 32'h00000080, 2'b11, 32'h00000013, 5'd10};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00000010, 32'h00000000, 2'b11, 5'd11, 1'b1, 1'b0, 32'h80ADBEEF, 2'b11, 32'h00000010, 5'd11};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h00000012, 32'h00000000, 2'b11, 5'd12, 1'b1, 1'b0, 32'hFFFF80AD, 2'b11, 32'h00000012, 5'd12};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, SZ_HALF, 1'b1, 32'h00000010, 32'h00000000, 2'b11, 5'd13, 1'b1, 1'b0, 32'h0000BEEF, 2'b11, 32'h00000010, 5'd13};
    vecs[8]  = '{1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'h00000011, 32'h00000000, 2'b11, 5'd14, 1'b1, 1'b0, 32'hFFFFFFBE, 2'b11, 32'h00000011, 5'd14};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 2'b11,   1'b0, 32'h12345678, 32'h00000000, 2'b01, 5'd15, 1'b1, 1'b0, 32'h00000000, 2'b01, 32'h12345678, 5'd15};
    vecs[10] = '{1'b0, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00000099, 32'h00000000, 2'b11, 5'd7,  1'b0, 1'b0, 32'h00000000, 2'b00, 32'h12345678, 5'd15};
    vecs[11] = '{1'b1, 1'b1, 1'b0, SZ_HALF, 1'b0, 32'h00000011, 32'h00000000, 2'b11, 5'd16, 1'b1, 1'b1, 32'h00000000, 2'b00, 32'h00000011, 5'd16};
    vecs[12] = '{1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h00000014, 32'h11223344, 2'b00, 5'd0,  1'b1, 1'b0, 32'h00000000, 2'b00, 32'h00000014, 5'd0};
    vecs[13] = '{1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h00000016, 32'hAAAAAAAA, 2'b01, 5'd1,  1'b1, 1'b1, 32'h00000000, 2'b00, 32'h00000016, 5'd1};
    vecs[14] = '{1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00000014, 32'h00000000, 2'b11, 5'd17, 1'b1, 1'b0, 32'h11223344, 2'b11, 32'h00000014, 5'd17};
    vecs[15] = '{1'b1, 1'b1, 1'b0, 2'b11,   1'b0, 32'h00000018, 32'h00000000, 2'b11, 5'd18, 1'b1, 1'b1, 32'h00000000, 2'b00, 32'h00000018, 5'd18};
    vecs[16] = '{1'b1, 1'b1, 1'b1, SZ_WORD, 1'b0, 32'h00000018, 32'h00000055, 2'b11, 5'd19, 1'b1, 1'b1, 32'h00000000, 2'b00, 32'h00000018, 5'd19};
    vecs[17] = '{1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00001010, 32'h00000000, 2'b11, 5'd20, 1'b1, 1'b0, 32'h80ADBEEF, 2'b11, 32'h00001010, 5'd20};
    vecs[18] = '{1'b1, 1'b0, 1'b1, SZ_HALF, 1'b0, 32'h00000016, 32'h0000CAFE, 2'b00, 5'd0,  1'b1, 1'b0, 32'h00000000, 2'b00, 32'h00000016, 5'd0};
    vecs[19] = '{1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h00000014, 32'h00000000, 2'b11, 5'd21, 1'b1, 1'b0, 32'hCAFE3344, 2'b11, 32'h00000014, 5'd21};
    vecs[20] = '{1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b1, 32'h00000017, 32'h00000000, 2'b11, 5'd22, 1'b1, 1'b0, 32'h000000CA, 2'b11, 32'h00000017, 5'd22};
    vecs[21] = '{1'b1, 1'b1, 1'b0, SZ_BYTE, 1'b0, 32'hFFFFF012, 32'h00000000, 2'b11, 5'd23, 1'b1, 1'b0, 32'hFFFFFFAD, 2'b11, 32'hFFFFF012, 5'd23};

    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", {31'h0, u0_out_valid}, 32'h0);
    chk("reset fault", {31'h0, u0_fault}, 32'h0);
    chk("reset read_data", u0_read_data, 32'h0);
    chk("reset alu_out", u0_alu_out, 32'h0);
    chk("reset wb_ctrl", {30'h0, u0_wb_ctrl_out}, 32'h0);
    chk("reset dest", {27'h0, u0_dest_reg_out}, 32'h0);
    chk("reset stall", {31'h0, u0_stall}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].v, vecs[i].rd, vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr,
            vecs[i].sd, vecs[i].wb, vecs[i].dest);
      edge1();
      chk($sformatf("v%0d out_valid", i), {31'h0, u0_out_valid}, {31'h0, vecs[i].ev});
      chk($sformatf("v%0d fault", i), {31'h0, u0_fault}, {31'h0, vecs[i].ef});
      chk($sformatf("v%0d read_data", i), u0_read_data, vecs[i].erd);
      chk($sformatf("v%0d wb_ctrl", i), {30'h0, u0_wb_ctrl_out}, {30'h0, vecs[i].ewb});
      chk($sformatf("v%0d alu_out", i), u0_alu_out, vecs[i].ealu);
      chk($sformatf("v%0d dest", i), {27'h0, u0_dest_reg_out}, {27'h0, vecs[i].edest});
      chk($sformatf("v%0d stall", i), {31'h0, u0_stall}, 32'h0);
    end

    // Asynchronous reset between edges clears the bundle immediately
    reset = 1'b1;
    #2;
    chk("async rst out_valid", {31'h0, u0_out_valid}, 32'h0);
    chk("async rst read_data", u0_read_data, 32'h0);
    chk("async rst alu_out", u0_alu_out, 32'h0);
    chk("async rst wb_ctrl", {30'h0, u0_wb_ctrl_out}, 32'h0);
    chk("async rst dest", {27'h0, u0_dest_reg_out}, 32'h0);
    chk("async rst stall", {31'h0, u2_stall}, 32'h0);

    // Two wait states: store, back-to-back load, then a non-memory op
    drive(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h5A5A0001, 2'b00, 5'd2);
    edge1();
    reset = 1'b0;
    edge1();
    chk("ws2 sw e0 stall", {31'h0, u2_stall}, 32'h1);
    chk("ws2 sw e0 valid", {31'h0, u2_out_valid}, 32'h0);
    drive(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h44, 32'h00000BAD, 2'b11, 5'd4);
    edge1();
    chk("ws2 sw e1 stall", {31'h0, u2_stall}, 32'h1);
    chk("ws2 sw e1 valid", {31'h0, u2_out_valid}, 32'h0);
    edge1();
    chk("ws2 sw e2 stall", {31'h0, u2_stall}, 32'h0);
    chk("ws2 sw e2 valid", {31'h0, u2_out_valid}, 32'h1);
    chk("ws2 sw alu_out", u2_alu_out, 32'h10);
    chk("ws2 sw wb_ctrl", {30'h0, u2_wb_ctrl_out}, 32'h0);
    drive(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 2'b11, 5'd9);
    for (int k = 0; k < 3; k++) begin
      edge1();
      chk($sformatf("ws2 lw e%0d stall", k), {31'h0, u2_stall}, (k < 2) ? 32'h1 : 32'h0);
      chk($sformatf("ws2 lw e%0d valid", k), {31'h0, u2_out_valid}, (k == 2) ? 32'h1 : 32'h0);
    end
    chk("ws2 lw read_data", u2_read_data, 32'h5A5A0001);
    chk("ws2 lw wb_ctrl", {30'h0, u2_wb_ctrl_out}, 32'h3);
    chk("ws2 lw dest", {27'h0, u2_dest_reg_out}, 32'h9);
    chk("ws2 lw fault", {31'h0, u2_fault}, 32'h0);
    drive(1'b1, 1'b0, 1'b0, SZ_WORD, 1'b0, 32'h77, 32'h0, 2'b01, 5'd3);
    edge1();
    chk("ws2 add valid", {31'h0, u2_out_valid}, 32'h1);
    chk("ws2 add stall", {31'h0, u2_stall}, 32'h0);
    chk("ws2 add alu_out", u2_alu_out, 32'h77);
    chk("ws2 add wb_ctrl", {30'h0, u2_wb_ctrl_out}, 32'h1);
    chk("ws2 add read_data", u2_read_data, 32'h0);

    // Three wait states: known store, then a store dropped by reset mid-WAIT
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'hCAFEF00D, 2'b00, 5'd0);
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk($sformatf("ws3 sw e%0d stall", k), {31'h0, u3_stall}, (k < 3) ? 32'h1 : 32'h0);
      chk($sformatf("ws3 sw e%0d valid", k), {31'h0, u3_out_valid}, (k == 3) ? 32'h1 : 32'h0);
    end
    drive(1'b1, 1'b0, 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h12345678, 2'b00, 5'd6);
    edge1();
    chk("ws3 sw2 e0 stall", {31'h0, u3_stall}, 32'h1);
    edge1();
    chk("ws3 sw2 e1 stall", {31'h0, u3_stall}, 32'h1);
    reset = 1'b1;
    #1;
    chk("ws3 rst stall", {31'h0, u3_stall}, 32'h0);
    chk("ws3 rst valid", {31'h0, u3_out_valid}, 32'h0);
    chk("ws3 rst alu_out", u3_alu_out, 32'h0);
    chk("ws3 rst read_data", u3_read_data, 32'h0);
    chk("ws3 rst wb_ctrl", {30'h0, u3_wb_ctrl_out}, 32'h0);
    chk("ws3 rst dest", {27'h0, u3_dest_reg_out}, 32'h0);
    chk("ws3 rst fault", {31'h0, u3_fault}, 32'h0);
    drive(1'b1, 1'b1, 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 2'b11, 5'd5);
    #1;
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      edge1();
      chk($sformatf("ws3 lw e%0d stall", k), {31'h0, u3_stall}, (k < 3) ? 32'h1 : 32'h0);
      chk($sformatf("ws3 lw e%0d valid", k), {31'h0, u3_out_valid}, (k == 3) ? 32'h1 : 32'h0);
    end
    chk("ws3 lw read_data", u3_read_data, 32'hCAFEF00D);
    chk("ws3 lw wb_ctrl", {30'h0, u3_wb_ctrl_out}, 32'h3);
    chk("ws3 lw dest", {27'h0, u3_dest_reg_out}, 32'h5);
    chk("ws3 lw alu_out", u3_alu_out, 32'h20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MIPS MEM pipeline stage, between EX/MEM and MEM/WB. Takes the EX/MEM bundle: control bits, ALU result as address, store data and destination register. It performs the load or store against an internal byte-addressable data RAM with a configurable number of wait states. It presents a registered, aligned and extended result to the MEM/WB register, and asserts `stall` upstream while an access is outstanding.

## Interface
- `DEPTH_W`, 10, log2 of RAM depth in 32-bit words; addresses wrap modulo 4·2^DEPTH_W bytes.
- `WAIT_STATES`, 0, extra cycles per memory access; allowed range 0–15.
- `clk` in 1: clock.
- `reset` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: EX/MEM holds a real instruction.
- `mem_read` in 1: load.
- `mem_write` in 1: store. `mem_read` and `mem_write` both high is a fault.
- `mem_size` in 2: 00 byte, 01 half, 10 word, 11 reserved (fault).
- `mem_unsigned` in 1: zero-extend loads, else sign-extend.
- `alu_result` in 32: byte address, also passed through.
- `store_data` in 32: rt value to store.
- `wb_ctrl_in` in 2: bit0 RegWrite, bit1 MemtoReg.
- `dest_reg_in` in 5: destination register.
- `stall` out 1: EX/MEM must hold its contents.
- `out_valid` out 1: the output bundle is a real instruction.
- `fault` out 1: misaligned or illegal access, valid with `out_valid`.
- `read_data` out 32: extended load data.
- `alu_out` out 32: passthrough of `alu_result`.
- `wb_ctrl_out` out 2: forced to 00 on a bubble or fault.
- `dest_reg_out` out 5: destination register.

## Operation
- **States.** IDLE and WAIT. A 4-bit wait counter `cnt` is used in WAIT.
- **IDLE, `in_valid`=0.** Outputs become a bubble on the next edge: `out_valid` 0, `wb_ctrl_out` 00, other outputs hold.
- **IDLE, non-memory op.** Applies when `in_valid`=1 and neither `mem_read` nor `mem_write` is set. The bundle is registered on the next edge with `out_valid` 1 and `read_data` 0.
- **IDLE, illegal access.** Applies when `mem_size`=11, the address is misaligned (half with `addr[0]`=1, word with `addr[1:0]`≠0), or both `mem_read` and `mem_write` are set.
  - The access completes immediately with `fault` 1 and `wb_ctrl_out` 00.
  - No RAM write occurs.
- **IDLE, legal access, `WAIT_STATES`=0.** The access completes on the accepting edge.
- **IDLE, legal access, `WAIT_STATES`>0.** The request is captured into internal registers and the stage moves to WAIT with `cnt`←`WAIT_STATES`.
- **WAIT.** Each edge decrements `cnt`. On the edge where `cnt`=1, the access completes and the stage returns to IDLE.
- **Completion.**
  - **Store:** lanes are written at that edge only.
  - **Load:** reads the word `addr[DEPTH_W+1:2]` and registers the extracted value.
  - **Outputs:** registered with `out_valid` 1.
- **Store lanes (little-endian).**
  - Byte: `store_data[7:0]` to lane `addr[1:0]`.
  - Half: `store_data[15:0]` to lanes {`addr[1]`,0} and {`addr[1]`,1}.
  - Word: all four lanes.
- **Load extract.**
  - Byte: lane `addr[1:0]`, extended per `mem_unsigned`.
  - Half: selected by `addr[1]`, extended per `mem_unsigned`.
  - Word: full word.
- **`read_data` on stores:** 0.
- **RAM contents:** not cleared by reset; initial contents are undefined.

## Timing
- `stall` = (state==WAIT), decoded from registered state only. It is high for exactly `WAIT_STATES` cycles after the accepting edge.
- **Latency.** Non-memory ops and faults: 1 edge. Legal accesses: `WAIT_STATES` edges after acceptance, with a minimum of 1 edge when `WAIT_STATES`=0.
- **Back-to-back.** While in WAIT, inputs are ignored. The instruction EX/MEM held during the stall is accepted on the first IDLE edge, giving no extra bubble.
- **Output bundle during WAIT:** `out_valid` 0, `wb_ctrl_out` 00.
- **Reset values:** all outputs 0, state IDLE, `cnt` 0.
- **Reset mid-WAIT:** the pending access is dropped and a pending store is not written.
- **Address wrap:** the upper address bits above `DEPTH_W+1` are ignored.

## Structure
- **Package `mips_mem_pkg`:**
  - Size encodings: `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - State enum: IDLE, WAIT.
  - wb_ctrl bit indices: `WB_REGWRITE`=0, `WB_MEMTOREG`=1.
- **Sub-module `data_ram_bytelane`:** synchronous-write, combinational-read RAM with a 4-bit byte-enable. The stage holds the FSM, alignment check, lane steering and extension.

## Test plan
1. **Reset.** Assert `reset` mid-simulation → all outputs 0 and `stall` 0 in the same cycle, asynchronously.
2. **Word round trip.** `WAIT_STATES`=0: `sw 0xDEADBEEF` @0x10, then `lw` @0x10 → `read_data` 0xDEADBEEF with `out_valid` 1 one edge after the `lw` is presented.
3. **Byte and half extension.** After test 2:
   - `sb 0x80` @0x13, then `lb` @0x13 → 0xFFFFFF80.
   - `lbu` @0x13 → 0x00000080.
   - `lw` @0x10 → 0x80ADBEEF.
   - `lh` @0x12 → 0xFFFF80AD.
4. **Wait states.** `WAIT_STATES`=2: `lw` accepted at edge 0 → `stall` high between edge 0 and edge 2, `out_valid` 0 during that time. Result valid after edge 2. The following `add` is accepted at edge 3 and is valid after edge 3.
5. **Misaligned accesses.**
   - `lh` @0x11 → `fault` 1, `wb_ctrl_out` 00, `out_valid` 1 after 1 edge.
   - `sw` @0x16 → `fault` 1, and a later `lw` @0x14 shows unchanged memory.
6. **Reset during a store.** `WAIT_STATES`=3: `sw 0x12345678` @0x20, `reset` pulsed in the second WAIT cycle → `stall` 0 and outputs 0. A subsequent `lw` @0x20 returns the pre-store value.
